// File: rtl/zero_ram_pkg.sv
// Shared types and constants for the zerocore RAM responder slice.
package zero_ram_pkg;

  localparam int RAM_DEPTH_LOG2 = 12;
  localparam int RAM_LAT_W      = 4;

  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_WAIT = 2'd1,
    RAM_RESP = 2'd2
  } ram_state_e;

endpackage

// File: rtl/zero_ram_array.sv
// Word-organised storage with per-bit masked write and combinational word read.
module zero_ram_array
  import zero_ram_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = RAM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] widx,
  input  logic [DATA_W-1:0]     wmask,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] ridx,
  output logic [DATA_W-1:0]     rword
);

  logic [DATA_W-1:0] mem [1<<DEPTH_LOG2];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= (mem[widx] & ~wmask) | (wdata & wmask);
  end

  assign rword = mem[ridx];

endmodule

// File: rtl/zero_ram_responder.sv
// RAM-port responder for zerocore: fixed-latency reads, single-cycle masked writes.
// Optional ZERO_RAM_ERR_EN adds the RamAccessErr out-of-range pulse output.
module zero_ram_responder
  import zero_ram_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = RAM_DEPTH_LOG2,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RamReadEnable,
  input  logic [ADDR_W-1:0] RamReadAddr,
  output logic              RamReadReady,
  output logic              RamReadValid,
  output logic [DATA_W-1:0] RamReadData,
  input  logic              RamWriteEnable,
  input  logic [ADDR_W-1:0] RamWriteAddr,
  input  logic [DATA_W-1:0] RamWriteMask,
  input  logic [DATA_W-1:0] RamWriteData,
  output logic [1:0]        dbg_state
`ifdef ZERO_RAM_ERR_EN
  ,
  output logic              RamAccessErr
`endif
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("zero_ram_responder: RD_LAT must be in 1..15");
  end

  localparam int HALF = DATA_W / 2;
  localparam logic [RAM_LAT_W-1:0] LAT_INIT =
    (RD_LAT > 1) ? RAM_LAT_W'(RD_LAT - 2) : '0;

  ram_state_e            state_q, state_d;
  logic [RAM_LAT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]     snap_q, snap_d, data_q;
  logic [DATA_W-1:0]     rd_word, merged, shaped;
  logic [DEPTH_LOG2-1:0] widx, ridx;
  logic                  wr_oob, rd_oob, wr_en, accept;
  logic                  unused_addr_bits;

  assign widx   = RamWriteAddr[DEPTH_LOG2+2:3];
  assign ridx   = RamReadAddr[DEPTH_LOG2+2:3];
  assign wr_oob = |RamWriteAddr[ADDR_W-1:DEPTH_LOG2+3];
  assign rd_oob = |RamReadAddr[ADDR_W-1:DEPTH_LOG2+3];
  assign wr_en  = RamWriteEnable & ~wr_oob;
  assign unused_addr_bits = ^{RamWriteAddr[2:0], RamReadAddr[1:0]};

  zero_ram_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (wr_en),
    .widx (widx),
    .wmask(RamWriteMask),
    .wdata(RamWriteData),
    .ridx (ridx),
    .rword(rd_word)
  );

  // Handshake: a read is taken on any edge where RamReadEnable and RamReadReady are both 1;
  // its data appears with a one-cycle RamReadValid strobe, and the core holds the request
  // unchanged while RamReadReady is 0. Writes have no handshake and are taken every enabled edge.
  assign accept = RamReadEnable & RamReadReady;

  // Write-first merge so a same-edge write to the read word is visible in the snapshot.
  assign merged = (wr_en && widx == ridx) ?
                  ((rd_word & ~RamWriteMask) | (RamWriteData & RamWriteMask)) : rd_word;
  assign shaped = rd_oob ? '0 :
                  (RamReadAddr[2] ? {merged[HALF-1:0], merged[DATA_W-1:HALF]} : merged);
  assign snap_d = accept ? shaped : snap_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RAM_IDLE, RAM_RESP: begin
        if (accept) begin
          if (RD_LAT == 1) begin
            state_d = RAM_RESP;
          end else begin
            state_d = RAM_WAIT;
            cnt_d   = LAT_INIT;
          end
        end else begin
          state_d = RAM_IDLE;
        end
      end
      RAM_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - RAM_LAT_W'(1);
        else             state_d = RAM_RESP;
      end
      default: state_d = RAM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RAM_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      if (state_d == RAM_RESP) data_q <= snap_d;
    end
  end

  assign RamReadValid = (state_q == RAM_RESP);
  assign RamReadReady = (state_q != RAM_WAIT);
  assign RamReadData  = data_q;
  assign dbg_state    = state_q;

`ifdef ZERO_RAM_ERR_EN
  logic err_snap_q, err_snap_d, err_q;

  assign err_snap_d = accept ? rd_oob : err_snap_q;

  // Read errors ride with the response strobe; write errors show one cycle after the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_snap_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_snap_q <= err_snap_d;
      err_q      <= ((state_d == RAM_RESP) & err_snap_d) | (RamWriteEnable & wr_oob);
    end
  end

  assign RamAccessErr = err_q;
`endif

endmodule

// File: tb/tb_zero_ram_responder.sv
// Bench for zero_ram_responder: instances at RD_LAT 1, 3 and 4 with a per-instance expected queue.
module tb_zero_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re   [3];
  logic [63:0] ra   [3];
  logic        rdy  [3];
  logic        vld  [3];
  logic [63:0] rd   [3];
  logic        we   [3];
  logic [63:0] wa   [3];
  logic [63:0] wm   [3];
  logic [63:0] wd   [3];
  logic [1:0]  st   [3];
`ifdef ZERO_RAM_ERR_EN
  logic        err  [3];
`endif

  logic [63:0] exp_q[$];
  logic [63:0] exp3_q[$];
  logic [63:0] exp4_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instance 0: RD_LAT=1, instance 1: RD_LAT=3, instance 2: RD_LAT=4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    zero_ram_responder #(.RD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
      .clk           (clk),
      .rst           (rst_n),
      .RamReadEnable (re[g]),
      .RamReadAddr   (ra[g]),
      .RamReadReady  (rdy[g]),
      .RamReadValid  (vld[g]),
      .RamReadData   (rd[g]),
      .RamWriteEnable(we[g]),
      .RamWriteAddr  (wa[g]),
      .RamWriteMask  (wm[g]),
      .RamWriteData  (wd[g]),
`ifdef ZERO_RAM_ERR_EN
      .RamAccessErr  (err[g]),
`endif
      .dbg_state     (st[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rot32(input logic [63:0] x);
    return {x[31:0], x[63:32]};
  endfunction

  task automatic push(input int i, input logic [63:0] e);
    case (i)
      0:       exp_q.push_back(e);
      1:       exp3_q.push_back(e);
      default: exp4_q.push_back(e);
    endcase
  endtask

  task automatic wr(input int i, input logic [63:0] a, input logic [63:0] m, input logic [63:0] d);
    we[i] = 1'b1; wa[i] = a; wm[i] = m; wd[i] = d;
    @(negedge clk);
    we[i] = 1'b0;
  endtask

  task automatic rdreq(input int i, input logic [63:0] a, input logic [63:0] e);
    bit acc = 1'b0;
    re[i] = 1'b1; ra[i] = a;
    for (int n = 0; n < 20; n++) begin
      acc = rdy[i];
      if (acc) push(i, e);
      @(negedge clk);
      if (acc) break;
    end
    re[i] = 1'b0;
    if (!acc) check("rd_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() + exp3_q.size() + exp4_q.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if ((exp_q.size() + exp3_q.size() + exp4_q.size()) != 0)
      check("drain_timeout", 64'(exp_q.size() + exp3_q.size() + exp4_q.size()), 0);
  endtask

  // Response monitor: every valid strobe consumes the oldest expectation of its instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vld[0]) begin
        if (exp_q.size() == 0) check("unexpected_valid0", 1, 0);
        else                   check("rdata_lat1", rd[0], exp_q.pop_front());
      end
      if (vld[1]) begin
        if (exp3_q.size() == 0) check("unexpected_valid3", 1, 0);
        else                    check("rdata_lat3", rd[1], exp3_q.pop_front());
      end
      if (vld[2]) begin
        if (exp4_q.size() == 0) check("unexpected_valid4", 1, 0);
        else                    check("rdata_lat4", rd[2], exp4_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mdl [8];
    logic [63:0] v, m, d, e;
    int w, r, h, lat, low;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      re[i] = 0; ra[i] = 0; we[i] = 0; wa[i] = 0; wm[i] = 0; wd[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", rdy[i], 1);
      check("rst_valid", vld[i], 0);
      check("rst_data",  rd[i],  0);
      check("rst_state", st[i],  0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Masked write then read back.
    wr(0, 64'h80, '1, 64'h1122334455667788);
    wr(0, 64'h80, 64'h00000000FFFF0000, '1);
    rdreq(0, 64'h80, 64'h11223344FFFF7788);

    // Instruction-fetch half select.
    wr(0, 64'h100, '1, 64'hAAAABBBBCCCCDDDD);
    rdreq(0, 64'h104, 64'hCCCCDDDDAAAABBBB);
    rdreq(0, 64'h100, 64'hAAAABBBBCCCCDDDD);
    drain();

    // RD_LAT=1 back-to-back reads: one valid per cycle, in order.
    wr(0, 64'h0,  '1, 64'h0000_0000_0000_0A0A);
    wr(0, 64'h8,  '1, 64'h0000_0000_0000_0B0B);
    wr(0, 64'h10, '1, 64'h0000_0000_0000_0C0C);
    re[0] = 1'b1; ra[0] = 64'h0;
    check("b2b_ready0", rdy[0], 1); push(0, 64'h0A0A);
    @(negedge clk);
    check("b2b_valid0", vld[0], 1);
    ra[0] = 64'h8;
    check("b2b_ready1", rdy[0], 1); push(0, 64'h0B0B);
    @(negedge clk);
    check("b2b_valid1", vld[0], 1);
    ra[0] = 64'h10;
    check("b2b_ready2", rdy[0], 1); push(0, 64'h0C0C);
    @(negedge clk);
    check("b2b_valid2", vld[0], 1);
    re[0] = 1'b0;
    @(negedge clk);
    check("b2b_idle", vld[0], 0);
    drain();

    // RD_LAT=4: valid on the 4th cycle after accept, ready low for the 3 WAIT cycles,
    // and the next read is taken in the RESP cycle.
    wr(2, 64'h200, '1, 64'h4444_0000_1111_2222);
    wr(2, 64'h208, '1, 64'h5555_6666_7777_8888);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        re[2] = 1'b1; ra[2] = 64'h200; push(2, 64'h4444_0000_1111_2222);
        @(negedge clk);
        re[2] = 1'b0;
      end
      lat = 0; low = 0;
      for (int k = 1; k <= 12; k++) begin
        if (vld[2]) begin lat = k; break; end
        if (!rdy[2]) low++;
        @(negedge clk);
      end
      check("lat4_latency", lat, 4);
      check("lat4_ready_low", low, 3);
      if (pass == 0) begin
        check("lat4_ready_in_resp", rdy[2], 1);
        re[2] = 1'b1; ra[2] = 64'h208; push(2, 64'h5555_6666_7777_8888);
        @(negedge clk);
        re[2] = 1'b0;
        check("lat4_accept_in_resp", rdy[2], 0);
      end
    end
    drain();

    // Collisions: same-edge write is merged; write during WAIT does not touch the snapshot.
    wr(0, 64'h180, '1, 64'h0123_4567_89AB_CDEF);
    we[0] = 1'b1; wa[0] = 64'h180; wm[0] = '1; wd[0] = 64'h5A5A5A5A5A5A5A5A;
    rdreq(0, 64'h180, 64'h5A5A5A5A5A5A5A5A);
    we[0] = 1'b0;
    wr(2, 64'h280, '1, 64'h0000_1111_0000_1111);
    rdreq(2, 64'h280, 64'h0000_1111_0000_1111);
    wr(2, 64'h280, '1, 64'hDEAD_BEEF_DEAD_BEEF);
    drain();
    rdreq(2, 64'h280, 64'hDEAD_BEEF_DEAD_BEEF);
    drain();

    // Out-of-range accesses: read returns 0, write is dropped (it would alias word 0).
    re[0] = 1'b1; ra[0] = 64'h0001_0000; push(0, 64'h0);
    @(negedge clk);
    re[0] = 1'b0;
`ifdef ZERO_RAM_ERR_EN
    check("oob_rd_err", err[0], 1);
    @(negedge clk);
    check("oob_rd_err_clear", err[0], 0);
`endif
    wr(0, 64'h0001_0000, '1, '1);
`ifdef ZERO_RAM_ERR_EN
    check("oob_wr_err", err[0], 1);
    @(negedge clk);
    check("oob_wr_err_clear", err[0], 0);
`endif
    rdreq(0, 64'h0, 64'h0A0A);
    drain();

    // Random masked writes and half-selected reads against a small word model.
    for (int i = 0; i < 8; i++) begin
      v = {$urandom, $urandom};
      wr(0, 64'h400 + 64'(i * 8), '1, v);
      mdl[i] = v;
    end
    for (int it = 0; it < 40; it++) begin
      w = $urandom_range(0, 7);
      m = {$urandom, $urandom};
      d = {$urandom, $urandom};
      wr(0, 64'h400 + 64'(w * 8) + 64'($urandom_range(0, 7)), m, d);
      mdl[w] = (mdl[w] & ~m) | (d & m);
      r = $urandom_range(0, 7);
      h = $urandom_range(0, 1);
      e = h ? rot32(mdl[r]) : mdl[r];
      rdreq(0, 64'h400 + 64'(r * 8) + 64'(h * 4), e);
    end
    drain();

    // Reset while RD_LAT=3 read is in WAIT: response dropped, outputs back to reset values at once.
    wr(1, 64'h300, '1, 64'hCAFE_F00D_1234_5678);
    rdreq(1, 64'h300, 64'hCAFE_F00D_1234_5678);
    drain();
    re[1] = 1'b1; ra[1] = 64'h300;
    @(negedge clk);
    re[1] = 1'b0;
    check("rst_pre_wait_ready", rdy[1], 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", vld[1], 0);
    check("rst_mid_ready", rdy[1], 1);
    check("rst_mid_data",  rd[1],  0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_stray_valid", vld[1], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
